// File: rtl/load_store_ctrl.sv
// load_store_ctrl: sequences one load/store (lw/lb/sw/sb) at a time against a
// single-port word memory with one-cycle read latency. Byte stores are done as
// read-modify-write of the containing word.
// Optional feature macro: LSU_MISALIGN_CHECK_EN -- when defined, word accesses
// whose effective address is not 4-byte aligned complete with resp_err=1 and
// never touch memory; when undefined the low address bits are ignored.
module load_store_ctrl #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic              req_byte,
   input  logic [31:0]       base,
   input  logic [11:0]       imediato,
   input  logic [31:0]       wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_word,
   output logic              mem_re,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_READ  = 3'd2,
      S_WAIT  = 3'd3,
      S_WRITE = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic                store_q, byte_q;
   logic [31:0]         base_q, wdata_q;
   logic [11:0]         imm_q;
   logic [ADDR_W+1:0]   ea_q, ea_d;
   logic                req_ready_q, req_ready_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;
   logic [31:0]         resp_data_q, resp_data_d;
   logic                mem_re_q, mem_re_d;
   logic                mem_we_q, mem_we_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic [31:0]         ea_calc_s;
   logic                misalign_s;
   logic [7:0]          rbyte_s;
   logic                unused_s;

   // Select byte lane 'lane' out of a little-endian word.
   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

   // Replace byte lane 'lane' of a word, keeping the other lanes.
   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [7:0] b);
      logic [31:0] w;
      w = word;
      case (lane)
         2'd0:    w[7:0]   = b;
         2'd1:    w[15:8]  = b;
         2'd2:    w[23:16] = b;
         default: w[31:24] = b;
      endcase
      return w;
   endfunction

   // Effective address; only the bits below ADDR_W+2 reach memory, so it wraps.
   assign ea_calc_s = base_q + {{20{imm_q[11]}}, imm_q};
   assign unused_s  = ^ea_calc_s[31:ADDR_W+2];
   assign rbyte_s   = lane_byte(mem_rdata, ea_q[1:0]);

`ifdef LSU_MISALIGN_CHECK_EN
   assign misalign_s = ~byte_q & (ea_calc_s[1:0] != 2'b00);
`else
   assign misalign_s = 1'b0;
`endif

   // State register plus request latch and registered outputs; reset aborts anything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         store_q      <= 1'b0;
         byte_q       <= 1'b0;
         base_q       <= 32'd0;
         imm_q        <= 12'd0;
         wdata_q      <= 32'd0;
         ea_q         <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= 32'd0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         if (state_q == S_IDLE && req_valid) begin
            store_q <= req_store;
            byte_q  <= req_byte;
            base_q  <= base;
            imm_q   <= imediato;
            wdata_q <= wdata;
         end
         ea_q         <= ea_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Next-state logic: one request at a time, requests outside IDLE are dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) state_d = S_CALC;
            else           state_d = S_IDLE;
         end
         S_CALC: begin
            if (misalign_s)              state_d = S_RESP;
            else if (store_q && !byte_q) state_d = S_WRITE;
            else                         state_d = S_READ;
         end
         S_READ:  state_d = S_WAIT;
         S_WAIT: begin
            if (store_q) state_d = S_WRITE;
            else         state_d = S_RESP;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output next-values, computed from the upcoming state so outputs line up with states.
   always_comb begin
      req_ready_d  = (state_d == S_IDLE);
      mem_re_d     = (state_d == S_READ);
      mem_we_d     = (state_d == S_WRITE);
      resp_valid_d = (state_d == S_RESP);
      ea_d         = ea_q;
      resp_err_d   = 1'b0;
      resp_data_d  = 32'd0;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         S_CALC: begin
            ea_d       = ea_calc_s[ADDR_W+1:0];
            resp_err_d = misalign_s;
            if (state_d == S_WRITE) mem_wdata_d = wdata_q;
            else                    mem_wdata_d = mem_wdata_q;
         end
         S_WAIT: begin
            if (store_q)     mem_wdata_d = lane_merge(mem_rdata, ea_q[1:0], wdata_q[7:0]);
            else if (byte_q) resp_data_d = {{24{rbyte_s[7]}}, rbyte_s};
            else             resp_data_d = mem_rdata;
         end
         default: begin
            resp_data_d = 32'd0;
         end
      endcase
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_data  = resp_data_q;
   assign mem_word   = ea_q[ADDR_W+1:2];
   assign mem_re     = mem_re_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Testbench for load_store_ctrl: table of directed load/store vectors against a
// behavioural word memory, plus hand sequences for reset and busy behaviour.
`timescale 1ns/1ps
module tb_load_store_ctrl;
   localparam int ADDR_W = 5;
`ifdef LSU_MISALIGN_CHECK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid, req_ready, req_store, req_byte;
   logic [31:0]       base, wdata;
   logic [11:0]       imediato;
   logic              resp_valid, resp_err;
   logic [31:0]       resp_data;
   logic [ADDR_W-1:0] mem_word;
   logic              mem_re, mem_we;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = 32'd0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   load_store_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_byte(req_byte), .base(base), .imediato(imediato),
      .wdata(wdata), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .mem_word(mem_word), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Word memory, one-cycle read latency; contents loaded once on the first reset.
   logic [31:0] mem [0:31];
   logic        mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (reset && !mem_loaded) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
         mem[1]     <= 32'h12345678;
         mem[4]     <= 32'h000000AA;
         mem[5]     <= 32'h80FF7F01;
         mem_loaded <= 1'b1;
      end else begin
         if (mem_re) mem_rdata <= mem[mem_word];
         if (mem_we) mem[mem_word] <= mem_wdata;
      end
   end

   typedef struct {
      logic        st;
      logic        by;
      logic [31:0] base;
      logic [11:0] imm;
      logic [31:0] wd;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;
      int          exp_re;
      int          exp_we;
      logic [4:0]  exp_word;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vt [16];

   function automatic vec_t mk(input logic st, input logic by, input logic [31:0] b,
                               input logic [11:0] imm, input logic [31:0] wd,
                               input logic [31:0] ed, input logic ee, input int lat,
                               input int re, input int we, input logic [4:0] w,
                               input logic [31:0] ewd);
      vec_t v;
      v.st = st; v.by = by; v.base = b; v.imm = imm; v.wd = wd;
      v.exp_data = ed; v.exp_err = ee; v.exp_lat = lat; v.exp_re = re; v.exp_we = we;
      v.exp_word = w; v.exp_wd = ewd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request from IDLE and follow it to its response.
   task automatic run_vec(input vec_t v, input int idx);
      int          lat, re_cnt, we_cnt;
      logic        both, err;
      logic [31:0] data, wd_seen;
      logic [4:0]  word_seen;
      lat = 0; re_cnt = 0; we_cnt = 0; both = 1'b0; err = 1'b0;
      data = 32'd0; wd_seen = 32'd0; word_seen = 5'd0;
      chk($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
      req_store = v.st; req_byte = v.by; base = v.base; imediato = v.imm; wdata = v.wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
         @(negedge clk);
         if (mem_re && mem_we) both = 1'b1;
         if (mem_re) begin re_cnt++; word_seen = mem_word; end
         if (mem_we) begin we_cnt++; word_seen = mem_word; wd_seen = mem_wdata; end
         if (resp_valid) begin lat = cyc; data = resp_data; err = resp_err; end
      end
      if (lat == 0) begin
         n_cmp++; n_err++;
         $display("FAIL v%0d_timeout: no resp_valid within 20 cycles", idx);
      end
      chk($sformatf("v%0d_lat", idx),  32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_data", idx), data, v.exp_data);
      chk($sformatf("v%0d_err", idx),  {31'd0, err}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_re", idx),   32'(re_cnt), 32'(v.exp_re));
      chk($sformatf("v%0d_we", idx),   32'(we_cnt), 32'(v.exp_we));
      chk($sformatf("v%0d_both", idx), {31'd0, both}, 32'd0);
      if (v.exp_re + v.exp_we > 0)
         chk($sformatf("v%0d_word", idx), {27'd0, word_seen}, {27'd0, v.exp_word});
      if (v.exp_we > 0)
         chk($sformatf("v%0d_wdata", idx), wd_seen, v.exp_wd);
      @(negedge clk);
      chk($sformatf("v%0d_after", idx), {30'd0, resp_valid, req_ready}, 32'd1);
   endtask

   initial begin
      int re_cnt, we_cnt, rv_cnt, nr_cnt;
      logic [31:0] wd_seen;
      logic [4:0]  word_seen;

      //        st    by    base           imm      wdata          exp_data       err lat re we word  exp_wdata
      vt[0]  = mk(1'b0, 1'b1, 32'h00000010, 12'h000, 32'h0,        32'hFFFFFFAA, 1'b0, 4, 1, 0, 5'd4, 32'h0);
      vt[1]  = mk(1'b1, 1'b1, 32'h00000010, 12'h002, 32'h00000055, 32'h0,        1'b0, 5, 1, 1, 5'd4, 32'h005500AA);
      vt[2]  = mk(1'b0, 1'b0, 32'h00000010, 12'h000, 32'h0,        32'h005500AA, 1'b0, 4, 1, 0, 5'd4, 32'h0);
      vt[3]  = mk(1'b1, 1'b0, 32'h00000020, 12'hFFC, 32'hDEADBEEF, 32'h0,        1'b0, 3, 0, 1, 5'd7, 32'hDEADBEEF);
      vt[4]  = mk(1'b0, 1'b0, 32'h0000001C, 12'h000, 32'h0,        32'hDEADBEEF, 1'b0, 4, 1, 0, 5'd7, 32'h0);
      vt[5]  = mk(1'b0, 1'b0, 32'hFFFFFFFC, 12'h008, 32'h0,        32'h12345678, 1'b0, 4, 1, 0, 5'd1, 32'h0);
      vt[6]  = mk(1'b0, 1'b1, 32'h00000014, 12'h001, 32'h0,        32'h0000007F, 1'b0, 4, 1, 0, 5'd5, 32'h0);
      vt[7]  = mk(1'b0, 1'b1, 32'h00000018, 12'hFFF, 32'h0,        32'hFFFFFF80, 1'b0, 4, 1, 0, 5'd5, 32'h0);
      vt[8]  = mk(1'b0, 1'b1, 32'h00000014, 12'h002, 32'h0,        32'hFFFFFFFF, 1'b0, 4, 1, 0, 5'd5, 32'h0);
      vt[9]  = mk(1'b1, 1'b1, 32'h00000014, 12'h000, 32'h12345633, 32'h0,        1'b0, 5, 1, 1, 5'd5, 32'h80FF7F33);
      vt[10] = mk(1'b0, 1'b0, 32'h00000014, 12'h000, 32'h0,        32'h80FF7F33, 1'b0, 4, 1, 0, 5'd5, 32'h0);
      vt[11] = MIS ? mk(1'b0, 1'b0, 32'h00000011, 12'h000, 32'h0,  32'h0,        1'b1, 2, 0, 0, 5'd0, 32'h0)
                   : mk(1'b0, 1'b0, 32'h00000011, 12'h000, 32'h0,  32'h005500AA, 1'b0, 4, 1, 0, 5'd4, 32'h0);
      vt[12] = mk(1'b1, 1'b0, 32'h0000007F, 12'h001, 32'hCAFEF00D, 32'h0,        1'b0, 3, 0, 1, 5'd0, 32'hCAFEF00D);
      vt[13] = mk(1'b0, 1'b0, 32'h00000080, 12'h000, 32'h0,        32'hCAFEF00D, 1'b0, 4, 1, 0, 5'd0, 32'h0);
      vt[14] = MIS ? mk(1'b1, 1'b0, 32'h00000021, 12'h000, 32'h0BADF00D, 32'h0, 1'b1, 2, 0, 0, 5'd0, 32'h0)
                   : mk(1'b1, 1'b0, 32'h00000021, 12'h000, 32'h0BADF00D, 32'h0, 1'b0, 3, 0, 1, 5'd8, 32'h0BADF00D);
      vt[15] = mk(1'b0, 1'b0, 32'h00000020, 12'h000, 32'h0, MIS ? 32'h00000008 : 32'h0BADF00D,
                  1'b0, 4, 1, 0, 5'd8, 32'h0);

      reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_byte = 1'b0;
      base = 32'd0; imediato = 12'd0; wdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready",  {31'd0, req_ready},  32'd1);
      chk("rst_strobe", {29'd0, resp_valid, mem_re, mem_we}, 32'd0);
      chk("rst_err",    {31'd0, resp_err},   32'd0);
      chk("rst_rdata",  resp_data, 32'd0);
      chk("rst_wdata",  mem_wdata, 32'd0);
      chk("rst_word",   {27'd0, mem_word}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) run_vec(vt[i], i);

      // Busy requests are dropped and latched fields stay stable.
      req_store = 1'b1; req_byte = 1'b0; base = 32'h28; imediato = 12'h000; wdata = 32'h13579BDF;
      req_valid = 1'b1;
      @(posedge clk);
      #1 base = 32'h10; req_store = 1'b0; wdata = 32'h0;
      re_cnt = 0; we_cnt = 0; rv_cnt = 0; wd_seen = 32'd0; word_seen = 5'd0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (cyc == 2) req_valid = 1'b0;
         if (mem_re) re_cnt++;
         if (mem_we) begin we_cnt++; wd_seen = mem_wdata; word_seen = mem_word; end
         if (resp_valid) rv_cnt++;
      end
      chk("busy_re",    32'(re_cnt), 32'd0);
      chk("busy_we",    32'(we_cnt), 32'd1);
      chk("busy_resp",  32'(rv_cnt), 32'd1);
      chk("busy_wdata", wd_seen, 32'h13579BDF);
      chk("busy_word",  {27'd0, word_seen}, 32'd10);

      // Reset while a byte store waits for read data: no write, no response.
      req_store = 1'b1; req_byte = 1'b1; base = 32'h10; imediato = 12'h001; wdata = 32'h77;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_read", {31'd0, mem_re}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ready",  {31'd0, req_ready}, 32'd1);
      chk("abort_strobe", {29'd0, resp_valid, mem_re, mem_we}, 32'd0);
      chk("abort_wdata",  mem_wdata, 32'd0);
      chk("abort_word",   {27'd0, mem_word}, 32'd0);
      reset = 1'b0;
      we_cnt = 0; rv_cnt = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         if (mem_we) we_cnt++;
         if (resp_valid) rv_cnt++;
      end
      chk("abort_we",   32'(we_cnt), 32'd0);
      chk("abort_resp", 32'(rv_cnt), 32'd0);
      run_vec(mk(1'b0, 1'b0, 32'h10, 12'h000, 32'h0, 32'h005500AA, 1'b0, 4, 1, 0, 5'd4, 32'h0), 16);

      // Reset wins over a request presented on the same edge.
      req_store = 1'b0; req_byte = 1'b0; base = 32'h10; imediato = 12'h000;
      req_valid = 1'b1; reset = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; reset = 1'b0;
      re_cnt = 0; rv_cnt = 0; nr_cnt = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (!req_ready) nr_cnt++;
         if (mem_re) re_cnt++;
         if (resp_valid) rv_cnt++;
         @(negedge clk);
      end
      chk("prio_ready", 32'(nr_cnt), 32'd0);
      chk("prio_re",    32'(re_cnt), 32'd0);
      chk("prio_resp",  32'(rv_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
